// File: rtl/mdu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_issue_ctrl_if
//  Description : Pipeline-to-MDU issue handshake bundle. The master modport is
//                the pipeline/testbench side and the slave modport is the issue
//                controller. Optional MDU_STALL_CNT_EN adds the stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
interface mdu_issue_ctrl_if;
    logic        d_valid;
    logic [31:0] d_instr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_hold;
    logic        e_kill;
    logic        md_busy;
    logic        md_start;
    logic [2:0]  md_op;
    logic        md_sel;
    logic        stall_d;
`ifdef MDU_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    modport master (
        output d_valid, d_instr, e_valid, e_instr, e_hold, e_kill, md_busy,
        input  md_start, md_op, md_sel, stall_d
`ifdef MDU_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  d_valid, d_instr, e_valid, e_instr, e_hold, e_kill, md_busy,
        output md_start, md_op, md_sel, stall_d
`ifdef MDU_STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_issue_ctrl
//  Description : Issues multiply/divide/mtlo/mthi operations from the E stage
//                to the MDU exactly once per instruction, tracks MDU occupancy
//                and stalls D-stage MDU-class instructions while it is busy.
//                Optional macro MDU_STALL_CNT_EN adds a 32-bit stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_issue_ctrl (
    input  wire logic         clk,
    input  wire logic         rst,
    mdu_issue_ctrl_if.slave   bus
);

    localparam logic [2:0] c_OP_NONE  = 3'd0;
    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;
    localparam logic [2:0] c_OP_MTHI  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Map an instruction to its MDU write-op code (0 when it is not one).
    function automatic logic [2:0] f_wr_op(input logic [31:0] ins);
        logic [2:0] op;
        op = c_OP_NONE;
        if (ins[31:26] == 6'd0) begin
            case (ins[5:0])
                6'h18:   op = c_OP_MULT;
                6'h19:   op = c_OP_MULTU;
                6'h1A:   op = c_OP_DIV;
                6'h1B:   op = c_OP_DIVU;
                6'h13:   op = c_OP_MTLO;
                6'h11:   op = c_OP_MTHI;
                default: op = c_OP_NONE;
            endcase
        end
        return op;
    endfunction

    // True for any of the eight MDU-class instructions, including reads.
    function automatic logic f_is_mdu(input logic [31:0] ins);
        return (f_wr_op(ins) != c_OP_NONE) ||
               (ins[31:26] == 6'd0 && (ins[5:0] == 6'h10 || ins[5:0] == 6'h12));
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_issued;
    logic       w_issued_nxt;
    logic [2:0] w_e_op;
    logic       w_e_muldiv;
    logic       w_eligible;
    logic       w_md_start;
    logic [2:0] w_md_op;
    logic       w_stall_d;

    assign w_e_op     = f_wr_op(bus.e_instr);
    assign w_e_muldiv = (w_e_op >= c_OP_MULT) && (w_e_op <= c_OP_DIVU);
    assign w_eligible = bus.e_valid && !bus.e_kill && (w_e_op != c_OP_NONE) && !r_issued;

    // Issue decisions, D-stage stall and FSM next state.
    always_comb begin
        w_md_start  = 1'b0;
        w_md_op     = c_OP_NONE;
        w_stall_d   = 1'b0;
        w_state_nxt = r_state;

        // A mul/div arriving while the MDU is still occupied is dropped:
        // upstream hazard logic is supposed to keep this from happening.
        if (w_eligible && !(w_e_muldiv && r_state != S_IDLE)) begin
            w_md_op = w_e_op;
        end
        w_md_start = w_eligible && w_e_muldiv && (r_state == S_IDLE);

        w_stall_d = bus.d_valid && f_is_mdu(bus.d_instr) &&
                    (w_md_start || r_state == S_START ||
                     (r_state == S_WAIT && bus.md_busy));

        case (r_state)
            S_IDLE:  if (w_md_start) w_state_nxt = S_START;
            // The MDU raises busy one cycle late, so busy is ignored here.
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (!bus.md_busy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Held instructions must not re-issue; any advance or kill re-arms.
    always_comb begin
        w_issued_nxt = r_issued;
        if (!bus.e_hold || bus.e_kill) begin
            w_issued_nxt = 1'b0;
        end else if (w_md_op != c_OP_NONE) begin
            w_issued_nxt = 1'b1;
        end
    end

    // State and issued-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_issued <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_issued <= w_issued_nxt;
        end
    end

    assign bus.md_start = w_md_start;
    assign bus.md_op    = w_md_op;
    assign bus.md_sel   = (bus.e_instr[31:26] == 6'd0) && (bus.e_instr[5:0] == 6'h10);
    assign bus.stall_d  = w_stall_d;

`ifdef MDU_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count every cycle the D stage is held for the MDU; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall_d) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_issue_ctrl
//  Description : Directed self-checking bench for mdu_issue_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_issue_ctrl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    mdu_issue_ctrl_if bus ();

    mdu_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // R-type instruction with given funct (non-zero register fields).
    function automatic logic [31:0] f_r(input logic [5:0] funct);
        return {6'd0, 5'd8, 5'd9, 5'd10, 5'd0, funct};
    endfunction

    logic [31:0] c_MULT, c_DIV, c_DIVU, c_MTLO, c_MTHI, c_MFHI, c_MFLO, c_ADDU, c_LW18;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply one cycle's inputs shortly after the active edge.
    task automatic drv(input logic dv, input logic [31:0] di, input logic ev,
                       input logic [31:0] ei, input logic eh, input logic ek,
                       input logic busy);
        bus.d_valid = dv;
        bus.d_instr = di;
        bus.e_valid = ev;
        bus.e_instr = ei;
        bus.e_hold  = eh;
        bus.e_kill  = ek;
        bus.md_busy = busy;
        #2;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        drv(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        c_MULT = f_r(6'h18);
        c_DIV  = f_r(6'h1A);
        c_DIVU = f_r(6'h1B);
        c_MTLO = f_r(6'h13);
        c_MTHI = f_r(6'h11);
        c_MFHI = f_r(6'h10);
        c_MFLO = f_r(6'h12);
        c_ADDU = f_r(6'h21);
        c_LW18 = {6'h23, 5'd8, 5'd9, 16'h0018};

        rst = 1'b1;
        idle_in();
        nxt(); nxt();
        rst = 1'b0;
        nxt();

        // Reset state
        idle_in();
        chk("rst_start", {31'd0, bus.md_start}, 32'd0);
        chk("rst_op",    {29'd0, bus.md_op},    32'd0);
        chk("rst_stall", {31'd0, bus.stall_d},  32'd0);
`ifdef MDU_STALL_CNT_EN
        chk("rst_cnt", bus.stall_cnt, 32'd0);
`endif
        nxt();

        // mult issue with mfhi waiting in D
        drv(1'b1, c_MFHI, 1'b1, c_MULT, 1'b0, 1'b0, 1'b0);
        chk("mult_start", {31'd0, bus.md_start}, 32'd1);
        chk("mult_op",    {29'd0, bus.md_op},    32'd1);
        chk("mult_stall", {31'd0, bus.stall_d},  32'd1);
        chk("mult_sel",   {31'd0, bus.md_sel},   32'd0);
        nxt();
        drv(1'b1, c_MFHI, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("start_stall", {31'd0, bus.stall_d},  32'd1);
        chk("start_pulse", {31'd0, bus.md_start}, 32'd0);
        nxt();
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, c_MFHI, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("wait_stall%0d", i), {31'd0, bus.stall_d}, 32'd1);
            nxt();
        end
        drv(1'b1, c_MFHI, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("busy_drop_stall", {31'd0, bus.stall_d}, 32'd0);
        nxt();
`ifdef MDU_STALL_CNT_EN
        idle_in();
        chk("stall_cnt7", bus.stall_cnt, 32'd7);
`endif
        // mfhi/mflo read selection in E
        drv(1'b0, 32'd0, 1'b1, c_MFHI, 1'b0, 1'b0, 1'b0);
        chk("sel_mfhi", {31'd0, bus.md_sel}, 32'd1);
        chk("mfhi_op",  {29'd0, bus.md_op},  32'd0);
        nxt();
        drv(1'b0, 32'd0, 1'b1, c_MFLO, 1'b0, 1'b0, 1'b0);
        chk("sel_mflo", {31'd0, bus.md_sel}, 32'd0);
        nxt();

        // divu held three cycles: single issue
        drv(1'b0, 32'd0, 1'b1, c_DIVU, 1'b1, 1'b0, 1'b0);
        chk("divu_op0",    {29'd0, bus.md_op},    32'd4);
        chk("divu_start0", {31'd0, bus.md_start}, 32'd1);
        nxt();
        for (int i = 1; i < 3; i++) begin
            drv(1'b0, 32'd0, 1'b1, c_DIVU, 1'b1, 1'b0, 1'b0);
            chk($sformatf("divu_op%0d", i),    {29'd0, bus.md_op},    32'd0);
            chk($sformatf("divu_start%0d", i), {31'd0, bus.md_start}, 32'd0);
            nxt();
        end
        idle_in();
        nxt();

        // mtlo held: flag alone suppresses repeats, then mthi issues fresh
        drv(1'b0, 32'd0, 1'b1, c_MTLO, 1'b1, 1'b0, 1'b0);
        chk("mtlo_hold_op0", {29'd0, bus.md_op}, 32'd5);
        nxt();
        drv(1'b0, 32'd0, 1'b1, c_MTLO, 1'b1, 1'b0, 1'b0);
        chk("mtlo_hold_op1", {29'd0, bus.md_op}, 32'd0);
        nxt();
        drv(1'b0, 32'd0, 1'b1, c_MTLO, 1'b0, 1'b0, 1'b0);
        chk("mtlo_hold_op2", {29'd0, bus.md_op}, 32'd0);
        nxt();
        drv(1'b0, 32'd0, 1'b1, c_MTHI, 1'b0, 1'b0, 1'b0);
        chk("mthi_op", {29'd0, bus.md_op}, 32'd6);
        nxt();

        // mtlo with addu in D, FSM must stay idle
        drv(1'b1, c_ADDU, 1'b1, c_MTLO, 1'b0, 1'b0, 1'b0);
        chk("mtlo_op",    {29'd0, bus.md_op},    32'd5);
        chk("mtlo_start", {31'd0, bus.md_start}, 32'd0);
        chk("mtlo_stall", {31'd0, bus.stall_d},  32'd0);
        nxt();
        // non-R opcode with mult funct bits is not MDU
        drv(1'b0, 32'd0, 1'b1, c_LW18, 1'b0, 1'b0, 1'b0);
        chk("lw_op", {29'd0, bus.md_op}, 32'd0);
        nxt();
        drv(1'b1, c_ADDU, 1'b1, c_MULT, 1'b0, 1'b0, 1'b0);
        chk("idle_after_mtlo", {31'd0, bus.md_start}, 32'd1);
        chk("addu_nostall",    {31'd0, bus.stall_d},  32'd0);
        nxt();
        // START: mul/div hazard, addu no stall, busy low ignored
        drv(1'b1, c_ADDU, 1'b1, c_DIV, 1'b0, 1'b0, 1'b0);
        chk("hazard_start", {31'd0, bus.md_start}, 32'd0);
        chk("hazard_op",    {29'd0, bus.md_op},    32'd0);
        chk("addu_start",   {31'd0, bus.stall_d},  32'd0);
        nxt();
        drv(1'b1, c_MFLO, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("wait_busy0_stall", {31'd0, bus.stall_d}, 32'd0);
        nxt();

        // killed div: no issue, FSM stays idle
        drv(1'b1, c_MFLO, 1'b1, c_DIV, 1'b0, 1'b1, 1'b0);
        chk("kill_op",    {29'd0, bus.md_op},    32'd0);
        chk("kill_start", {31'd0, bus.md_start}, 32'd0);
        chk("kill_stall", {31'd0, bus.stall_d},  32'd0);
        nxt();
        drv(1'b1, c_MFLO, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("kill_after_stall", {31'd0, bus.stall_d}, 32'd0);
        nxt();

        // reset during WAIT with busy high
        drv(1'b0, 32'd0, 1'b1, c_MULT, 1'b0, 1'b0, 1'b0);
        chk("rst_seq_start", {31'd0, bus.md_start}, 32'd1);
        nxt();
        drv(1'b1, c_MFLO, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        nxt();
        drv(1'b1, c_MFLO, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("wait_mflo_stall", {31'd0, bus.stall_d}, 32'd1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        drv(1'b1, c_MFLO, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_stall", {31'd0, bus.stall_d}, 32'd0);
`ifdef MDU_STALL_CNT_EN
        chk("post_rst_cnt", bus.stall_cnt, 32'd0);
`endif
        nxt();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
